// File: rtl/fp_arb_pkg.sv
// Shared types and constants for the fp_adder arbiter: widths, default latency,
// the owner tag carried alongside each addition, and double constants.
package fp_arb_pkg;

  localparam int FP_W        = 64;
  localparam int DEF_ADD_LAT = 3;
  // Sized for the largest supported requester count (8).
  localparam int ID_W        = 3;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  localparam logic [FP_W-1:0] ONE   = 64'h3FF0000000000000;
  localparam logic [FP_W-1:0] TWO   = 64'h4000000000000000;
  localparam logic [FP_W-1:0] THREE = 64'h4008000000000000;

endpackage

// File: rtl/fp_add_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or after ptr,
// returning a one-hot grant and its encoded index. Purely combinational.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             hold,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx
);

  int j;

  // Walk offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = 0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      j = (int'(ptr) + off) % NREQ;
      if (req[j] && !hold) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one pipelined fp_adder among NREQ requesters: round-robin issue,
// registered operands, owner tag pipe matched to the adder latency.
module fp_add_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ADD_LAT = DEF_ADD_LAT,
  parameter int FP_W    = fp_arb_pkg::FP_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*FP_W-1:0] req_a,
  input  logic [NREQ*FP_W-1:0] req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [FP_W-1:0]      add_a,
  output logic [FP_W-1:0]      add_b,
  input  logic [FP_W-1:0]      add_sum,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [FP_W-1:0]      rsp_data,
  output logic                 busy
);

  localparam int IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] ptr_next;
  logic [NREQ-1:0]  gnt;
  logic [NREQ-1:0]  rsp_dec;
  logic             issue;
  tag_t             tag_in;
  tag_t             tag_pipe [ADD_LAT];

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .hold (hold),
    .gnt  (gnt),
    .idx  (gnt_idx)
  );

  assign req_ready = gnt;
  assign issue     = |gnt;
  assign ptr_next  = (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    tag_in       = '0;
    tag_in.valid = issue;
    tag_in.id    = ID_W'(gnt_idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      add_a  <= '0;
      add_b  <= '0;
    end else if (issue) begin
      rr_ptr <= ptr_next;
      add_a  <= req_a[int'(gnt_idx)*FP_W +: FP_W];
      add_b  <= req_b[int'(gnt_idx)*FP_W +: FP_W];
    end
  end

  // Tag shifts every cycle: the adder never stalls, so position == age.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < ADD_LAT; s++) tag_pipe[s] <= '0;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int s = 1; s < ADD_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  // The response flop adds the final cycle so rsp lines up with add_sum.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_dec
      assign rsp_dec[gi] = tag_pipe[ADD_LAT-1].valid &&
                           (tag_pipe[ADD_LAT-1].id == ID_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rsp_valid <= '0;
    else     rsp_valid <= rsp_dec;
  end

  assign rsp_data = add_sum;

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < ADD_LAT; s++) busy = busy | tag_pipe[s].valid;
  end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Self-checking bench for fp_add_arbiter: per-cycle grant table, a scoreboard
// of expected responses, and hand sequences for back-to-back issue and reset.
module tb_fp_add_arbiter;
  import fp_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 hold;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*64-1:0]   req_a;
  logic [NREQ*64-1:0]   req_b;
  logic [NREQ-1:0]      req_ready;
  logic [63:0]          add_a, add_b, add_sum;
  logic [NREQ-1:0]      rsp_valid;
  logic [63:0]          rsp_data;
  logic                 busy;

  fp_add_arbiter #(.NREQ(NREQ), .ADD_LAT(LAT), .FP_W(64)) dut (
    .clk(clk), .rst(rst), .hold(hold), .req_valid(req_valid),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the external pipelined adder.
  logic [63:0] apipe [LAT];
  initial for (int s = 0; s < LAT; s++) apipe[s] = '0;
  always @(posedge clk) begin
    apipe[0] <= $realtobits($bitstoreal(add_a) + $bitstoreal(add_b));
    for (int s = 1; s < LAT; s++) apipe[s] <= apipe[s-1];
  end
  assign add_sum = apipe[LAT-1];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [63:0] sum;
    int          due;
  } exp_t;
  exp_t sb[$];
  int   exp_ptr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Scoreboard monitor: own round-robin model, expected busy and responses.
  logic [NREQ-1:0] eg, er;
  logic [63:0]     ed;
  logic            eb;
  int              gid, jj;
  exp_t            e;
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_ptr = 0;
    end else begin
      eg = '0; gid = -1;
      if (!hold)
        for (int off = 0; off < NREQ; off++) begin
          jj = (exp_ptr + off) % NREQ;
          if (req_valid[jj] && gid < 0) begin eg[jj] = 1'b1; gid = jj; end
        end
      chk($sformatf("grant c%0d", cyc), 64'(req_ready), 64'(eg));
      eb = 1'b0;
      foreach (sb[k]) if (sb[k].due - LAT <= cyc && cyc < sb[k].due) eb = 1'b1;
      chk($sformatf("busy c%0d", cyc), 64'(busy), 64'(eb));
      er = '0; ed = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        er[e.id] = 1'b1;
        ed = e.sum;
      end
      chk($sformatf("rsp_valid c%0d", cyc), 64'(rsp_valid), 64'(er));
      if (er != '0) chk($sformatf("rsp_data c%0d", cyc), rsp_data, ed);
      if (gid >= 0) begin
        sb.push_back('{id: gid, due: cyc + 1 + LAT,
                       sum: $realtobits($bitstoreal(req_a[gid*64 +: 64]) +
                                        $bitstoreal(req_b[gid*64 +: 64]))});
        exp_ptr = (gid + 1) % NREQ;
      end
    end
  end

  typedef struct {
    logic [NREQ-1:0] vld;
    logic            hld;
    logic [NREQ-1:0] ready;
  } row_t;
  row_t tbl [19];

  task automatic drive(input logic [NREQ-1:0] v, input logic h, input int r);
    req_valid = v;
    hold      = h;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*64 +: 64] = (r == 0) ? ONE : $realtobits(real'(r + 1));
      req_b[i*64 +: 64] = (r == 0) ? TWO : $realtobits(real'(i) * 0.5);
    end
  endtask

  initial begin
    // From rr_ptr=0: single req, rotation, sparse 1010 with wrap, 5-cycle hold.
    tbl[0]  = '{4'b0001, 1'b0, 4'b0001};
    tbl[1]  = '{4'b0000, 1'b0, 4'b0000};
    tbl[2]  = '{4'b0000, 1'b0, 4'b0000};
    tbl[3]  = '{4'b0000, 1'b0, 4'b0000};
    tbl[4]  = '{4'b1111, 1'b0, 4'b0010};
    tbl[5]  = '{4'b1111, 1'b0, 4'b0100};
    tbl[6]  = '{4'b1111, 1'b0, 4'b1000};
    tbl[7]  = '{4'b1111, 1'b0, 4'b0001};
    tbl[8]  = '{4'b1111, 1'b0, 4'b0010};
    tbl[9]  = '{4'b1010, 1'b0, 4'b1000};
    tbl[10] = '{4'b1010, 1'b0, 4'b0010};
    tbl[11] = '{4'b1010, 1'b0, 4'b1000};
    for (int r = 12; r < 17; r++) tbl[r] = '{4'b1111, 1'b1, 4'b0000};
    tbl[17] = '{4'b1111, 1'b0, 4'b0001};
    tbl[18] = '{4'b0000, 1'b0, 4'b0000};

    rst = 1'b1;
    drive('0, 1'b0, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset add_a", add_a, 64'd0);
    chk("reset add_b", add_b, 64'd0);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);

    for (int r = 0; r < 19; r++) begin
      drive(tbl[r].vld, tbl[r].hld, r);
      @(negedge clk);
      chk($sformatf("table row %0d ready", r), 64'(req_ready), 64'(tbl[r].ready));
      @(posedge clk); #1;
    end
    repeat (LAT + 1) begin drive('0, 1'b0, 1); @(posedge clk); #1; end

    // Back-to-back single requester: ONE+ONE then TWO+ONE.
    drive(4'b0100, 1'b0, 1);
    req_a[2*64 +: 64] = ONE; req_b[2*64 +: 64] = ONE;
    @(posedge clk); #1;
    req_a[2*64 +: 64] = TWO; req_b[2*64 +: 64] = ONE;
    @(posedge clk); #1;
    drive('0, 1'b0, 1);
    repeat (LAT - 1) @(posedge clk);
    #1 chk("b2b first sum", rsp_data, TWO);
    chk("b2b first owner", 64'(rsp_valid), 64'(4'b0100));
    @(posedge clk); #1;
    chk("b2b second sum", rsp_data, THREE);
    chk("b2b second owner", 64'(rsp_valid), 64'(4'b0100));
    repeat (3) @(posedge clk); #1;

    // Three ops in flight, then an asynchronous reset pulse mid-cycle.
    for (int r = 0; r < 3; r++) begin
      drive(4'b1111, 1'b0, r + 20);
      @(posedge clk); #1;
    end
    drive('0, 1'b0, 1);
    #2 rst = 1'b1;
    #1;
    chk("async rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("async rst add_a", add_a, 64'd0);
    chk("async rst add_b", add_b, 64'd0);
    chk("async rst busy", 64'(busy), 64'd0);
    #3 rst = 1'b0;
    repeat (LAT + 3) @(posedge clk);
    #1 drive(4'b1111, 1'b0, 30);
    @(negedge clk);
    chk("post-reset ptr grant", 64'(req_ready), 64'(4'b0001));
    @(posedge clk); #1;
    drive('0, 1'b0, 1);

    begin
      int t = 0;
      while (sb.size() != 0 && t < 30) begin @(posedge clk); t++; end
      n_cmp++;
      if (sb.size() != 0) begin
        n_bad++;
        $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
      end
    end
    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_add_arbiter.md
Name: fp_add_arbiter

Overview:
- Shares one pipelined double-precision fp_adder among NREQ requesters in the G.729 front end: HPF sections, LPC windowing and autocorrelation accumulation.
- Round-robin grant, at most one issue per cycle.
- Registers the operands into the adder and tracks an owner tag through the fixed adder latency.
- Returns each sum to its owner with a one-hot valid.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADD_LAT, 3, fp_adder pipeline latency in cycles, from registered inputs to sum output.
- FP_W, 64, operand width (IEEE-754 double bit pattern).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- hold  in  1  suppresses all grants while high; in-flight ops complete.
- req_valid  in  NREQ  requester i has an operand pair.
- req_a  in  NREQ*FP_W  operand A, requester i at bits [i*FP_W +: FP_W].
- req_b  in  NREQ*FP_W  operand B, same packing.
- req_ready  out  NREQ  one-hot or zero; grant to requester i this cycle.
- add_a  out  FP_W  registered operand A to fp_adder.
- add_b  out  FP_W  registered operand B to fp_adder.
- add_sum  in  FP_W  fp_adder result.
- rsp_valid  out  NREQ  one-hot or zero; sum belongs to requester i.
- rsp_data  out  FP_W  sum (equals add_sum).
- busy  out  1  any operation in flight.

Behaviour:
- Reset (async, any time):
  - rr_ptr=0; tag pipe cleared; add_a=add_b=0; rsp_valid=0; busy=0.
  - In-flight operations are discarded; no rsp is ever produced for them.
- Grant:
  - req_ready is combinational from req_valid, rr_ptr and hold.
  - The first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NREQ, gets req_ready[i]=1.
  - If hold=1 or no req_valid, req_ready=0.
- Handshake:
  - Transfer at a rising edge where req_valid[i]&req_ready[i]=1.
  - Requester holds req_valid and its operands stable until the transfer.
  - req_valid must not depend on req_ready.
  - Deasserting req_valid before the transfer is allowed; the op is simply not issued.
- Issue (transfer edge k):
  - add_a/add_b <= requester i operands.
  - Tag stage 0 <= {valid=1, id=i}.
  - rr_ptr <= (i+1) mod NREQ, wrapping NREQ-1 -> 0.
  - With no transfer: add_a/add_b hold their value, tag stage 0 valid=0, rr_ptr unchanged.
- Tag pipe:
  - ADD_LAT stages of {valid, id}, shifting every cycle unconditionally (fp_adder has no stall).
- Response:
  - After edge k+ADD_LAT, rsp_valid[i]=1 for exactly one cycle.
  - rsp_data=add_sum, combinational pass-through.
  - Latency is exactly ADD_LAT cycles from transfer edge to response.
  - No response backpressure; requesters must accept.
- Throughput:
  - 1 op/cycle aggregate.
  - A single continuously-valid requester with others idle is granted every cycle.
  - All requesters valid: each granted once per NREQ cycles.
- busy = OR of all tag valid bits.
- Simultaneous events:
  - Issue and response in the same cycle are independent.
  - hold rising mid-stream: no new issue from that cycle; responses for already-issued ops still appear.
- Results are in issue order; ids per requester are in order.

Decomposition:
- Package fp_arb_pkg:
  - FP_W.
  - Default ADD_LAT.
  - tag struct {valid, id[$clog2(NREQ)-1:0]}.
  - Double constants for test: ONE=64'h3FF0000000000000, TWO=64'h4000000000000000, THREE=64'h4008000000000000.
- Sub-module rr_arbiter (NREQ): req, ptr, hold -> one-hot gnt and encoded idx.
- Top: operand mux/registers, tag shift pipe, response decode.
- fp_adder is instantiated outside, by the parent.

Test Plan:
- Reset then single req: req_valid[0]=1, a=ONE, b=TWO at edge 1 -> req_ready[0]=1 same cycle; rsp_valid=4'b0001 with rsp_data=THREE after edge 1+ADD_LAT; busy high for ADD_LAT cycles.
- All 4 valid continuously from ptr=0 -> grant order 0,1,2,3,0,1...; rsp_valid sequence follows the same order ADD_LAT cycles later; no idle cycles.
- req_valid=4'b1010, ptr=2 -> grant 3 then 1 then 3; ptr wraps 3->0 correctly and skips idle 0/2.
- hold=1 for 5 cycles with all valid -> req_ready=0; earlier in-flight ops still respond; on hold release the grant resumes at the saved rr_ptr.
- Async rst pulse mid-cycle with 3 ops in flight -> rsp_valid=0 immediately and never asserts for those ops; rr_ptr=0, add_a=add_b=0.
- Single requester valid every cycle with changing operands (ONE+ONE, TWO+ONE) -> back-to-back grants; rsp_data TWO then THREE on consecutive cycles.
